// File: rtl/pulse2lvl.sv
// Pulse-to-level converter: stretches or toggles a level on rising-edge events,
// with optional retrigger, a forced low gap and a saturating dropped-event count.
module pulse2lvl #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             mode,
    input  logic             retrig_en,
    input  logic             missed_clr,
    output logic             lvl,
    output logic             busy,
    output logic [CNT_W-1:0] missed_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] missed_nx;
    logic             lvl_nx;
    logic             prev;
    logic             evt;
    logic             drop;

    assign evt  = pulse & ~prev;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lvl        <= 1'b0;
            prev       <= 1'b0;
            missed_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            lvl        <= lvl_nx;
            prev       <= pulse;
            missed_cnt <= missed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lvl_nx   = lvl;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mode) begin
                    if (evt) begin
                        lvl_nx = ~lvl;
                    end
                end else if (evt) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LOAD;
                    lvl_nx   = 1'b1;
                end else begin
                    lvl_nx = 1'b0;
                end
            end
            HOLD: begin
                // a retrigger on the expiry cycle beats the expiry
                if (evt && retrig_en) begin
                    cnt_nx = HOLD_LOAD;
                    lvl_nx = 1'b1;
                end else begin
                    drop = evt;
                    if (cnt == '0) begin
                        lvl_nx = 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx = GAP;
                            cnt_nx   = GAP_LOAD;
                        end
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
            end
            GAP: begin
                drop   = evt;
                lvl_nx = 1'b0;
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                lvl_nx   = 1'b0;
            end
        endcase
    end

    always_comb begin
        missed_nx = missed_cnt;
        if (missed_clr) begin
            missed_nx = '0;
        end else if (drop && (missed_cnt != '1)) begin
            missed_nx = missed_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_pulse2lvl.sv
// Scoreboard bench for pulse2lvl: stimulus pushes per-cycle expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_pulse2lvl;

    logic       clk;
    logic       reset;
    logic       pulse;
    logic       mode;
    logic       retrig_en;
    logic       missed_clr;
    logic       lvl;
    logic       busy;
    logic [7:0] missed_cnt;

    typedef struct {
        logic       lvl;
        logic       busy;
        logic [7:0] missed;
        string      name;
        int         idx;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string cur      = "init";
    int    idx      = 0;
    int    dropped;

    pulse2lvl #(
        .HOLD_CYCLES(16),
        .GAP_CYCLES (2),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .mode      (mode),
        .retrig_en (retrig_en),
        .missed_clr(missed_clr),
        .lvl       (lvl),
        .busy      (busy),
        .missed_cnt(missed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({lvl, busy, missed_cnt} !== {e.lvl, e.busy, e.missed}) begin
                n_fail++;
                $display("FAIL %s step %0d: lvl=%0b busy=%0b missed=%0d, want lvl=%0b busy=%0b missed=%0d",
                         e.name, e.idx, lvl, busy, missed_cnt, e.lvl, e.busy, e.missed);
            end
        end
    end

    task automatic step(input logic p, input logic md, input logic rt,
                        input logic clr, input logic el, input logic eb,
                        input logic [7:0] em);
        exp_t e;
        @(negedge clk);
        pulse      = p;
        mode       = md;
        retrig_en  = rt;
        missed_clr = clr;
        e.lvl    = el;
        e.busy   = eb;
        e.missed = em;
        e.name   = cur;
        e.idx    = idx;
        sb.push_back(e);
        idx++;
    endtask

    task automatic check(input string name, input logic [9:0] got,
                         input logic [9:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        reset      = 1'b0;
        pulse      = 1'b0;
        mode       = 1'b0;
        retrig_en  = 1'b0;
        missed_clr = 1'b0;
        #1 reset = 1'b1;
        #20;
        check("reset_state", {lvl, busy, missed_cnt}, 10'h000);
        reset = 1'b0;

        cur = "single";
        idx = 0;
        for (int i = 0; i < 20; i++)
            step(i == 0, 0, 0, 0, i < 16, i < 18, 8'd0);

        cur = "retrig";
        idx = 0;
        for (int i = 0; i < 30; i++)
            step(i == 0 || i == 10, 0, 1, 0, i < 26, i < 28, 8'd0);

        cur = "retrig_expiry";
        idx = 0;
        for (int i = 0; i < 36; i++)
            step(i == 0 || i == 16, 0, 1, 0, i < 32, i < 34, 8'd0);

        cur = "drop";
        idx = 0;
        for (int i = 0; i < 21; i++)
            step(i == 0 || i == 5 || i == 17, 0, 0, 0, i < 16, i < 18,
                 (i >= 17) ? 8'd2 : ((i >= 5) ? 8'd1 : 8'd0));
        step(0, 0, 0, 1, 0, 0, 8'd0);

        cur = "gap_last";
        idx = 0;
        for (int i = 0; i < 21; i++)
            step(i == 0 || i == 18, 0, 0, 0, i < 16, i < 18,
                 (i >= 18) ? 8'd1 : 8'd0);
        step(0, 0, 0, 1, 0, 0, 8'd0);

        cur = "held";
        idx = 0;
        for (int i = 0; i < 60; i++)
            step(i < 50, 0, 1, 0, i < 16, i < 18, 8'd0);

        cur = "mode_in_hold";
        idx = 0;
        for (int i = 0; i < 21; i++)
            step(i == 0, i >= 1, 0, 0, i < 16, i < 18, 8'd0);

        cur = "toggle";
        idx = 0;
        for (int i = 0; i < 25; i++)
            step(i == 5 || i == 10 || i == 20, 1, 0, 0,
                 (i >= 5 && i < 10) || i >= 20, 0, 8'd0);

        cur = "toggle_exit";
        idx = 0;
        step(0, 0, 0, 0, 0, 0, 8'd0);

        cur = "pre_reset";
        idx = 0;
        for (int i = 0; i < 6; i++)
            step(i == 0 || i == 3, 0, 0, 0, 1, 1, (i >= 3) ? 8'd1 : 8'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        pulse = 1'b1;
        #1;
        check("async_reset", {lvl, busy, missed_cnt}, 10'h000);
        @(posedge clk);
        #1;
        check("reset_held", {lvl, busy, missed_cnt}, 10'h000);
        #1 reset = 1'b0;

        cur = "first_edge";
        idx = 0;
        for (int i = 0; i < 20; i++)
            step(i < 10, 0, 0, 0, i < 16, i < 18, 8'd0);

        cur = "saturate";
        idx = 0;
        dropped = 0;
        for (int i = 0; i < 682; i++) begin
            if ((i % 2 == 0) && (i % 20 != 0) && dropped < 255)
                dropped++;
            step(i % 2 == 0, 0, 0, 0, (i % 20) < 16, (i % 20) < 18,
                 8'(dropped));
        end
        cur = "clr_vs_drop";
        idx = 0;
        step(1, 0, 0, 1, 1, 1, 8'd0);
        step(0, 0, 0, 0, 1, 1, 8'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
